prio_irq_encoder: RTL and testbench
===================================

Name: prio_irq_encoder

Overview:
Parametrised, registered priority encoder for N request lines.
- Captures request pulses into sticky pending bits and applies a per-line mask.
- Presents the index of one winning line with a valid/ack handshake.
- Supports fixed-priority mode (highest index wins) and round-robin mode.
- Sits between peripheral request/interrupt lines and a single service agent.

Parameters:
N, 8, number of request lines (2..32)
IDX_W, 3, index width; must equal clog2(N)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
req  input  N  request lines, level or single-cycle pulse; sampled every cycle
mask  input  N  1 = line ineligible for selection; pending bit is still captured
rr_mode  input  1  0 = fixed priority, 1 = round-robin
out_idx  output  IDX_W  index of the presented line
out_valid  output  1  out_idx holds a valid grant
out_ack  input  1  consumer accepts the grant; meaningful only when out_valid=1
pending  output  N  registered sticky pending vector

Behaviour:
- Reset: one clock, synchronous, active-low. While rst_n=0 at a rising edge:
  - pending=0, out_valid=0, out_idx=0, last_grant=0, state=IDLE.
  - req and out_ack are ignored.
  - Reset asserted mid-PRESENT drops the grant without clearing any other state beyond the reset values.
- Pending update, every edge: pending <= (pending & ~clr) | req.
  - clr = onehot(out_idx) when state=PRESENT and out_ack=1, else 0.
  - If a new req arrives on the line being cleared in the same cycle, that line stays set (set wins).
- eligible = pending & ~mask, evaluated combinationally from registered pending.
- State machine with two states:
  - IDLE: if eligible != 0, register out_idx = select(eligible), set out_valid=1, go to PRESENT. Otherwise stay; out_valid=0.
  - PRESENT: out_idx and out_valid are held stable regardless of req, mask or rr_mode changes. No retraction.
    - On out_ack=1: last_grant <= out_idx, clear that pending bit (per rule above), out_valid=0, go to IDLE.
  - Throughput: at most one grant per 2 cycles. IDLE always lasts at least one cycle between grants.
- out_ack while out_valid=0 is ignored.
- Latency: req high in the cycle before edge k gives pending set after edge k, and out_valid=1 after edge k+1, when IDLE and the line is eligible and winning.
- select(), fixed mode (rr_mode=0): highest set index of eligible.
- select(), round-robin mode (rr_mode=1): search order is last_grant-1, last_grant-2, … (mod N), ending at last_grant.
  - The most recently granted line has lowest priority.
  - With last_grant=0 the order equals fixed mode.
- last_grant updates on every ack in both modes. rr_mode changes take effect at the next IDLE selection.
- Masked lines stay pending until unmasked and granted. Masking a line does not clear it.
- All-masked or empty: remain in IDLE with out_valid=0 and out_idx holding its last value.
- Widths: all index arithmetic is modulo N. For N not a power of 2, the wrap is explicit, and indices ≥ N are never produced.

Test Plan:
1. Reset: req=0xFF with rst_n=0 for 2 cycles -> out_valid=0, pending=0x00, out_idx=0. Release rst_n with req=0 -> out_valid stays 0.
2. Fixed order: rr_mode=0, one-cycle req=0x29, out_ack tied 1 -> grants 5, 3, 0 on successive valid cycles (IDLE cycle between each). pending goes 0x29 -> 0x09 -> 0x01 -> 0x00.
3. Mask: pending=0x81, mask=0x80 -> grant 0, pending 0x80 retained with out_valid=0. Set mask=0x00 -> grant 7 two edges later.
4. Round-robin: rr_mode=1, req held at 0x0F, ack every grant -> out_idx sequence 3, 2, 1, 0, 3, 2. Same stimulus with rr_mode=0 -> 3, 3, 3.
5. Hold and set-wins:
   - With out_valid=1, out_idx=4, out_ack low for 5 cycles while toggling mask=0xFF and req -> out_idx stays 4 and out_valid stays 1.
   - Then assert out_ack together with req[4]=1 -> pending[4] remains 1, and line 4 is re-granted after one IDLE cycle (fixed mode, no higher line pending).
6. Reset mid-grant: rst_n=0 for one cycle while PRESENT with pending=0x0C -> next cycle out_valid=0, pending=0x00, last_grant=0.

Source files
------------

// File: rtl/prio_irq_encoder.sv
// rtl/prio_irq_encoder.sv - registered N-line priority encoder with sticky pending, mask and fixed/round-robin select
module prio_irq_encoder #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     mask,
  input  logic             rr_mode,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_valid,
  input  logic             out_ack,
  output logic [N-1:0]     pending
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] last_grant_nx;
  logic [IDX_W-1:0] out_idx_nx;
  logic             out_valid_nx;
  logic [N-1:0]     pending_nx;
  logic [N-1:0]     eligible;
  logic [N-1:0]     clr;
  logic [IDX_W-1:0] sel_fixed;
  logic [IDX_W-1:0] sel_rr;
  logic [IDX_W-1:0] sel;
  int               rr_pos;

  // Masked lines keep their pending bit; they are only hidden from selection.
  assign eligible = pending & ~mask;

  // Fixed priority: ascending scan, so the highest set index is the last to overwrite.
  always_comb begin
    sel_fixed = '0;
    for (int i = 0; i < N; i++) begin
      if (eligible[IDX_W'(i)]) begin
        sel_fixed = IDX_W'(i);
      end
    end
  end

  // Round-robin: search order last_grant-1, last_grant-2, ... wrapping to last_grant.
  // Scan from the far end of that order so the nearest hit overwrites; the wrap is
  // explicit so no index >= N is formed when N is not a power of two.
  always_comb begin
    sel_rr = '0;
    rr_pos = 0;
    for (int k = N; k >= 1; k--) begin
      rr_pos = int'(last_grant) + N - k;
      if (rr_pos >= N) begin
        rr_pos = rr_pos - N;
      end
      if (eligible[IDX_W'(rr_pos)]) begin
        sel_rr = IDX_W'(rr_pos);
      end
    end
  end

  assign sel = rr_mode ? sel_rr : sel_fixed;

  // Next-state, grant and pending-clear logic; the grant is frozen while presented.
  always_comb begin
    state_nx      = state;
    out_idx_nx    = out_idx;
    out_valid_nx  = out_valid;
    last_grant_nx = last_grant;
    clr           = '0;
    case (state)
      IDLE: begin
        out_valid_nx = 1'b0;
        if (|eligible) begin
          out_idx_nx   = sel;
          out_valid_nx = 1'b1;
          state_nx     = PRESENT;
        end
      end
      PRESENT: begin
        if (out_ack) begin
          clr           = N'(1) << out_idx;
          last_grant_nx = out_idx;
          out_valid_nx  = 1'b0;
          state_nx      = IDLE;
        end
      end
      default: begin
        out_valid_nx = 1'b0;
        state_nx     = IDLE;
      end
    endcase
    // A new request on the line being cleared keeps it set.
    pending_nx = (pending & ~clr) | req;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      pending    <= '0;
      out_idx    <= '0;
      out_valid  <= 1'b0;
      last_grant <= '0;
    end else begin
      state      <= state_nx;
      pending    <= pending_nx;
      out_idx    <= out_idx_nx;
      out_valid  <= out_valid_nx;
      last_grant <= last_grant_nx;
    end
  end

endmodule

// File: tb/tb_prio_irq_encoder.sv
// tb/tb_prio_irq_encoder.sv - scoreboard bench for prio_irq_encoder
module tb_prio_irq_encoder;

  localparam int N     = 8;
  localparam int IDX_W = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req = '0;
  logic [N-1:0]     mask = '0;
  logic             rr_mode = 1'b0;
  logic             out_ack = 1'b0;
  logic [IDX_W-1:0] out_idx;
  logic             out_valid;
  logic [N-1:0]     pending;

  int errors = 0;
  int checks = 0;
  logic [IDX_W-1:0] sb[$];

  always #5 clk = ~clk;

  prio_irq_encoder #(.N(N), .IDX_W(IDX_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .mask      (mask),
    .rr_mode   (rr_mode),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ack   (out_ack),
    .pending   (pending)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int v);
    sb.push_back(IDX_W'(v));
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    check(name, sb.size(), 0);
  endtask

  // Monitor: every accepted grant is compared with the next expected index.
  initial begin
    logic [IDX_W-1:0] exp_idx;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ack) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_grant: got idx %0d expected no grant", out_idx);
        end else begin
          exp_idx = sb.pop_front();
          check("grant_idx", out_idx, exp_idx);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    // Reset with requests active
    rst_n = 1'b0;
    req   = 8'hFF;
    tick();
    tick();
    check("rst_valid", out_valid, 0);
    check("rst_pending", pending, 8'h00);
    check("rst_idx", out_idx, 0);
    rst_n = 1'b1;
    req   = 8'h00;
    tick();
    tick();
    check("rst_release_valid", out_valid, 0);
    check("rst_release_pending", pending, 8'h00);

    // Fixed order 5, 3, 0 from a single pulse
    out_ack = 1'b1;
    rr_mode = 1'b0;
    mask    = 8'h00;
    push(5); push(3); push(0);
    req = 8'h29;
    tick();
    req = 8'h00;
    check("fix_pend0", pending, 8'h29);
    tick();
    check("fix_first_valid", out_valid, 1);
    check("fix_first_idx", out_idx, 5);
    tick();
    check("fix_pend1", pending, 8'h09);
    tick();
    tick();
    check("fix_pend2", pending, 8'h01);
    tick();
    tick();
    check("fix_pend3", pending, 8'h00);
    drain("fix_drain");

    // Mask keeps line 7 pending until unmasked
    mask = 8'h80;
    push(0);
    req = 8'h81;
    tick();
    req = 8'h00;
    check("mask_pend0", pending, 8'h81);
    tick();
    tick();
    check("mask_pend1", pending, 8'h80);
    tick();
    check("mask_idle_valid", out_valid, 0);
    check("mask_retained", pending, 8'h80);
    push(7);
    mask = 8'h00;
    drain("mask_drain");
    check("mask_pend_final", pending, 8'h00);

    // Round-robin with req held, starting after a grant of line 7
    rr_mode = 1'b1;
    push(3); push(2); push(1); push(0); push(3); push(2);
    req = 8'h0F;
    drain("rr_drain");
    out_ack = 1'b0;
    req     = 8'h00;
    rst_n   = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rr_reset_pending", pending, 8'h00);

    // Same stimulus in fixed mode
    rr_mode = 1'b0;
    push(3); push(3); push(3);
    req     = 8'h0F;
    out_ack = 1'b1;
    drain("fixrep_drain");
    out_ack = 1'b0;
    req     = 8'h00;
    rst_n   = 1'b0;
    tick();
    rst_n = 1'b1;

    // Grant held stable while mask, req and rr_mode change
    req = 8'h10;
    tick();
    req = 8'h00;
    tick();
    check("hold_start_valid", out_valid, 1);
    check("hold_start_idx", out_idx, 4);
    for (int i = 0; i < 5; i++) begin
      mask    = (i % 2 == 0) ? 8'hFF : 8'h00;
      req     = (i % 2 == 0) ? 8'h01 : 8'h02;
      rr_mode = (i % 2 == 0);
      tick();
      check("hold_valid", out_valid, 1);
      check("hold_idx", out_idx, 4);
    end

    // Ack together with a new req on the same line: set wins
    mask    = 8'h00;
    rr_mode = 1'b0;
    req     = 8'h10;
    out_ack = 1'b1;
    push(4);
    tick();
    req = 8'h00;
    check("setwin_pend4", pending[4], 1);
    check("setwin_idle_valid", out_valid, 0);
    push(4); push(1); push(0);
    tick();
    check("regrant_valid", out_valid, 1);
    check("regrant_idx", out_idx, 4);
    drain("setwin_drain");

    // Leave last_grant at 1, then reset mid-grant
    push(1);
    req = 8'h02;
    tick();
    req = 8'h00;
    drain("pre_rst_drain");
    out_ack = 1'b0;
    req     = 8'h0C;
    tick();
    req = 8'h00;
    tick();
    check("mid_valid", out_valid, 1);
    check("mid_pending", pending, 8'h0C);
    check("mid_idx", out_idx, 3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_valid", out_valid, 0);
    check("midrst_pending", pending, 8'h00);
    check("midrst_idx", out_idx, 0);

    // last_grant cleared by reset: round-robin behaves like fixed order
    rr_mode = 1'b1;
    out_ack = 1'b1;
    push(2); push(0);
    req = 8'h05;
    tick();
    req = 8'h00;
    drain("midrst_rr_drain");
    tick();
    tick();
    check("final_pending", pending, 8'h00);
    check("final_queue", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
